// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop input synchronizer, centre-of-bit sampling FSM,
// one-cycle data-valid and frame-error strobes.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 20
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [7:0]       byte_d;
  logic             dv_d, err_d;
  logic             rx_p0, rx_p1;
  logic             rx_s;

  // Stage p0/p1: metastability synchronizer, idles high
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= i_Rx_Serial;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  always_comb begin
    state_d   = state;
    clk_cnt_d = clk_cnt;
    bit_idx_d = bit_idx;
    byte_d    = o_Rx_Byte;
    dv_d      = 1'b0;
    err_d     = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = 3'd0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (clk_cnt == CNT_MID) begin
          clk_cnt_d = '0;
          // Line back high at mid start bit means it was only a glitch
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_d       = '0;
          byte_d[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
            bit_idx_d = 3'd0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_d = '0;
          dv_d      = rx_s;
          err_d     = !rx_s;
          state_d   = CLEANUP;
        end else begin
          clk_cnt_d = clk_cnt + 1'b1;
        end
      end
      CLEANUP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        clk_cnt_d = '0;
        bit_idx_d = 3'd0;
      end
    endcase
  end

  // Stage p2: FSM state and registered outputs
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state          <= IDLE;
      clk_cnt        <= '0;
      bit_idx        <= 3'd0;
      o_Rx_Byte      <= 8'h00;
      o_Rx_DV        <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
    end else begin
      state          <= state_d;
      clk_cnt        <= clk_cnt_d;
      bit_idx        <= bit_idx_d;
      o_Rx_Byte      <= byte_d;
      o_Rx_DV        <= dv_d;
      o_Rx_Frame_Err <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: a behavioural serial transmitter drives the line and
// received bytes are compared against the list of bytes that were sent.
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int CPB = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       dv;
  logic [7:0] rbyte;
  logic       ferr;

  int checks = 0;
  int errors = 0;

  int dv_cnt = 0, err_cnt = 0, both_cnt = 0, wide_cnt = 0;
  logic dv_prev = 1'b0, err_prev = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_Rx_Serial    (rx),
    .o_Rx_DV        (dv),
    .o_Rx_Byte      (rbyte),
    .o_Rx_Frame_Err (ferr)
  );

  always #50 clk = ~clk;

  // Strobe monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (dv) begin
      rx_q.push_back(rbyte);
      dv_cnt++;
    end
    if (ferr) err_cnt++;
    if (dv && ferr) both_cnt++;
    if ((dv && dv_prev) || (ferr && err_prev)) wide_cnt++;
    dv_prev  = dv;
    err_prev = ferr;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Ideal 8N1 transmitter; must be called at a negedge and returns at one
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (dv !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b, required 0", dv); end
    checks++;
    if (rbyte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h, required 00", rbyte); end
    checks++;
    if (ferr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", ferr); end
    rst = 1'b0;
    idle(5);
    rx_q.delete();
    checks++;
    if (dv_cnt != 0 || err_cnt != 0) begin
      errors++; $display("FAIL reset_nostrobe: dv %0d err %0d, required 0 0", dv_cnt, err_cnt);
    end
  endtask

  task automatic test_single;
    int d0, e0;
    d0 = dv_cnt; e0 = err_cnt;
    send_frame(8'hA5, 1'b1);
    idle(10);
    checks++;
    if (dv_cnt - d0 != 1) begin errors++; $display("FAIL single_dv_count: got %0d, required 1", dv_cnt - d0); end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      errors++; $display("FAIL single_byte: got %0d bytes first %h, required 1 byte a5", rx_q.size(), rx_q.size() ? rx_q[0] : 8'h00);
    end
    checks++;
    if (rbyte !== 8'hA5) begin errors++; $display("FAIL single_hold: got %h, required a5", rbyte); end
    checks++;
    if (err_cnt != e0) begin errors++; $display("FAIL single_err: got %0d errors, required 0", err_cnt - e0); end
    rx_q.delete();
  endtask

  task automatic test_back_to_back;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(10);
    checks++;
    if (rx_q.size() != 2) begin
      errors++; $display("FAIL b2b_count: got %0d, required 2", rx_q.size());
    end else begin
      checks++;
      if (rx_q[0] !== 8'h00 || rx_q[1] !== 8'hFF) begin
        errors++; $display("FAIL b2b_bytes: got %h %h, required 00 ff", rx_q[0], rx_q[1]);
      end
    end
    rx_q.delete();
  endtask

  task automatic test_glitch;
    int d0, e0;
    d0 = dv_cnt; e0 = err_cnt;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(3 * CPB);
    checks++;
    if (dv_cnt != d0 || err_cnt != e0) begin
      errors++; $display("FAIL glitch_strobe: dv %0d err %0d, required 0 0", dv_cnt - d0, err_cnt - e0);
    end
    send_frame(8'h3C, 1'b1);
    idle(10);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
      errors++; $display("FAIL glitch_next: got %0d bytes first %h, required 1 byte 3c", rx_q.size(), rx_q.size() ? rx_q[0] : 8'h00);
    end
    rx_q.delete();
  endtask

  task automatic test_frame_err;
    int d0, e0;
    d0 = dv_cnt; e0 = err_cnt;
    send_frame(8'h81, 1'b0);
    idle(3 * CPB);
    checks++;
    if (err_cnt - e0 != 1) begin errors++; $display("FAIL ferr_pulse: got %0d, required 1", err_cnt - e0); end
    checks++;
    if (dv_cnt != d0) begin errors++; $display("FAIL ferr_nodv: got %0d, required 0", dv_cnt - d0); end
    send_frame(8'h42, 1'b1);
    idle(10);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h42) begin
      errors++; $display("FAIL ferr_recover: got %0d bytes first %h, required 1 byte 42", rx_q.size(), rx_q.size() ? rx_q[0] : 8'h00);
    end
    rx_q.delete();
  endtask

  task automatic test_reset_midframe;
    logic [7:0] b;
    int d0, e0;
    b = 8'h5A;
    d0 = dv_cnt; e0 = err_cnt;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = b[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    checks++;
    if (dv !== 1'b0 || ferr !== 1'b0 || rbyte !== 8'h00) begin
      errors++; $display("FAIL midreset_out: dv %b err %b byte %h, required 0 0 00", dv, ferr, rbyte);
    end
    idle(12 * CPB);
    checks++;
    if (dv_cnt != d0 || err_cnt != e0) begin
      errors++; $display("FAIL midreset_strobe: dv %0d err %0d, required 0 0", dv_cnt - d0, err_cnt - e0);
    end
    send_frame(8'h96, 1'b1);
    idle(10);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h96) begin
      errors++; $display("FAIL midreset_next: got %0d bytes first %h, required 1 byte 96", rx_q.size(), rx_q.size() ? rx_q[0] : 8'h00);
    end
    rx_q.delete();
  endtask

  task automatic test_random(input int n);
    logic [7:0] b;
    int gap;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1);
      gap = $urandom_range(0, 3);
      if (gap > 0) idle(gap * 7);
    end
    idle(10);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL random_count: got %0d, required %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL random_byte[%0d]: got %h, required %h", i, rx_q[i], exp_q[i]);
        end
      end
    end
    rx_q.delete();
  endtask

  task automatic test_loopback;
    int w0;
    w0 = wide_cnt;
    test_random(3);
    checks++;
    if (wide_cnt != w0) begin
      errors++; $display("FAIL loop_width: got %0d wide pulses, required 0", wide_cnt - w0);
    end
  endtask

  task automatic test_strobe_rules;
    checks++;
    if (both_cnt != 0) begin errors++; $display("FAIL strobe_overlap: got %0d, required 0", both_cnt); end
    checks++;
    if (wide_cnt != 0) begin errors++; $display("FAIL strobe_width: got %0d, required 0", wide_cnt); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_midframe();
    test_random(16);
    test_loopback();
    test_strobe_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
